// File: rtl/ram_read_scheduler_if.sv
// Bundle of requester, response, writer and block-RAM signals shared by the
// read scheduler and its clients. The slave modport is the scheduler side.
interface ram_read_scheduler_if #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TAG_W   = 8
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*TAG_W-1:0]  req_tag;

   logic [NUM_REQ-1:0]        resp_valid;
   logic [NUM_REQ*DATA_W-1:0] resp_data;
   logic [NUM_REQ*TAG_W-1:0]  resp_tag;
   logic [NUM_REQ-1:0]        resp_err;

   logic                      wr_valid;
   logic                      wr_ready;
   logic [ADDR_W-1:0]         wr_addr;
   logic [DATA_W-1:0]         wr_data;

   logic                      ram_write_enabled;
   logic [ADDR_W-1:0]         ram_write_address;
   logic [DATA_W-1:0]         ram_write_value;
   logic [ADDR_W-1:0]         ram_read_address;
   logic [DATA_W-1:0]         ram_read_value;
   logic [ADDR_W-1:0]         ram_read_address2;
   logic [DATA_W-1:0]         ram_read_value2;

   modport slave (
      input  req_valid, req_addr, req_tag,
      input  wr_valid, wr_addr, wr_data,
      input  ram_read_value, ram_read_value2,
      output req_ready,
      output resp_valid, resp_data, resp_tag, resp_err,
      output wr_ready,
      output ram_write_enabled, ram_write_address, ram_write_value,
      output ram_read_address, ram_read_address2
   );

   modport master (
      output req_valid, req_addr, req_tag,
      output wr_valid, wr_addr, wr_data,
      output ram_read_value, ram_read_value2,
      input  req_ready,
      input  resp_valid, resp_data, resp_tag, resp_err,
      input  wr_ready,
      input  ram_write_enabled, ram_write_address, ram_write_value,
      input  ram_read_address, ram_read_address2
   );
endinterface

// File: rtl/ram_read_scheduler.sv
// Round-robin scheduler granting up to two tagged reads per cycle onto the two
// read ports of a block RAM, plus a registered single write path.
module ram_read_scheduler #(
   parameter int NUM_REQ   = 3,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int TAG_W     = 8,
   parameter int RAM_DEPTH = 700
) (
   input  logic                 clk,
   input  logic                 rst,
   ram_read_scheduler_if.slave  bus
);
   localparam int              IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(RAM_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
   logic [TAG_W-1:0]   tag_arr  [NUM_REQ];
   logic [NUM_REQ-1:0] eligible;

   logic [IDX_W-1:0]   rr_ptr_reg;
   logic [IDX_W-1:0]   rr_ptr_next;

   logic               grant_a_valid;
   logic [IDX_W-1:0]   grant_a_idx;
   logic               grant_b_valid;
   logic [IDX_W-1:0]   grant_b_idx;
   logic [IDX_W-1:0]   last_idx;

   logic [ADDR_W-1:0]  rd_addr_a_reg;
   logic [ADDR_W-1:0]  rd_addr_b_reg;
   logic               slot_a_valid_reg;
   logic [IDX_W-1:0]   slot_a_idx_reg;
   logic [TAG_W-1:0]   slot_a_tag_reg;
   logic               slot_a_err_reg;
   logic               slot_b_valid_reg;
   logic [IDX_W-1:0]   slot_b_idx_reg;
   logic [TAG_W-1:0]   slot_b_tag_reg;
   logic               slot_b_err_reg;

   logic               wr_en_reg;
   logic [ADDR_W-1:0]  wr_addr_reg;
   logic [DATA_W-1:0]  wr_data_reg;
   logic               wr_in_range;

   // A read to the address being written this cycle would see stale data,
   // so it waits until the write has committed.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
         assign tag_arr[gi]  = bus.req_tag[gi*TAG_W +: TAG_W];
         assign eligible[gi] = bus.req_valid[gi] && !rst &&
                               !(bus.wr_valid && (addr_arr[gi] == bus.wr_addr));
      end
   endgenerate

   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
      int sum;
      sum = int'(base) + k;
      if (sum >= NUM_REQ) begin
         sum = sum - NUM_REQ;
      end
      return IDX_W'(sum);
   endfunction

   function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
      return {1'b0, addr} >= DEPTH_EXT;
   endfunction

   always_comb begin
      grant_a_valid = 1'b0;
      grant_a_idx   = '0;
      grant_b_valid = 1'b0;
      grant_b_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (eligible[wrap_idx(rr_ptr_reg, k)]) begin
            if (!grant_a_valid) begin
               grant_a_valid = 1'b1;
               grant_a_idx   = wrap_idx(rr_ptr_reg, k);
            end else if (!grant_b_valid) begin
               grant_b_valid = 1'b1;
               grant_b_idx   = wrap_idx(rr_ptr_reg, k);
            end
         end
      end
   end

   always_comb begin
      last_idx    = grant_b_valid ? grant_b_idx : grant_a_idx;
      rr_ptr_next = rr_ptr_reg;
      if (grant_a_valid) begin
         rr_ptr_next = (last_idx == LAST_IDX) ? '0 : last_idx + 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign bus.req_ready[gi] = (grant_a_valid && (grant_a_idx == IDX_W'(gi))) ||
                                    (grant_b_valid && (grant_b_idx == IDX_W'(gi)));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_reg       <= '0;
         rd_addr_a_reg    <= '0;
         rd_addr_b_reg    <= '0;
         slot_a_valid_reg <= 1'b0;
         slot_a_idx_reg   <= '0;
         slot_a_tag_reg   <= '0;
         slot_a_err_reg   <= 1'b0;
         slot_b_valid_reg <= 1'b0;
         slot_b_idx_reg   <= '0;
         slot_b_tag_reg   <= '0;
         slot_b_err_reg   <= 1'b0;
      end else begin
         rr_ptr_reg       <= rr_ptr_next;
         slot_a_valid_reg <= grant_a_valid;
         slot_b_valid_reg <= grant_b_valid;
         if (grant_a_valid) begin
            rd_addr_a_reg  <= addr_arr[grant_a_idx];
            slot_a_idx_reg <= grant_a_idx;
            slot_a_tag_reg <= tag_arr[grant_a_idx];
            slot_a_err_reg <= out_of_range(addr_arr[grant_a_idx]);
         end
         if (grant_b_valid) begin
            rd_addr_b_reg  <= addr_arr[grant_b_idx];
            slot_b_idx_reg <= grant_b_idx;
            slot_b_tag_reg <= tag_arr[grant_b_idx];
            slot_b_err_reg <= out_of_range(addr_arr[grant_b_idx]);
         end
      end
   end

   assign bus.ram_read_address  = rd_addr_a_reg;
   assign bus.ram_read_address2 = rd_addr_b_reg;

   // Each requester owns its response registers; a requester can sit in at
   // most one slot, so port A and port B never collide here.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
         logic              resp_valid_reg;
         logic [DATA_W-1:0] resp_data_reg;
         logic [TAG_W-1:0]  resp_tag_reg;
         logic              resp_err_reg;
         logic              hit_a;
         logic              hit_b;

         assign hit_a = slot_a_valid_reg && (slot_a_idx_reg == IDX_W'(gi));
         assign hit_b = slot_b_valid_reg && (slot_b_idx_reg == IDX_W'(gi));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               resp_valid_reg <= 1'b0;
               resp_data_reg  <= '0;
               resp_tag_reg   <= '0;
               resp_err_reg   <= 1'b0;
            end else begin
               resp_valid_reg <= hit_a || hit_b;
               if (hit_a) begin
                  resp_data_reg <= slot_a_err_reg ? '0 : bus.ram_read_value;
                  resp_tag_reg  <= slot_a_tag_reg;
                  resp_err_reg  <= slot_a_err_reg;
               end else if (hit_b) begin
                  resp_data_reg <= slot_b_err_reg ? '0 : bus.ram_read_value2;
                  resp_tag_reg  <= slot_b_tag_reg;
                  resp_err_reg  <= slot_b_err_reg;
               end
            end
         end

         assign bus.resp_valid[gi]                  = resp_valid_reg;
         assign bus.resp_data[gi*DATA_W +: DATA_W]  = resp_data_reg;
         assign bus.resp_tag[gi*TAG_W +: TAG_W]     = resp_tag_reg;
         assign bus.resp_err[gi]                    = resp_err_reg;
      end
   endgenerate

   assign bus.wr_ready = !rst;
   assign wr_in_range  = !out_of_range(bus.wr_addr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_reg   <= 1'b0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
      end else begin
         wr_en_reg <= bus.wr_valid && wr_in_range;
         if (bus.wr_valid && wr_in_range) begin
            wr_addr_reg <= bus.wr_addr;
            wr_data_reg <= bus.wr_data;
         end
      end
   end

   assign bus.ram_write_enabled = wr_en_reg;
   assign bus.ram_write_address = wr_addr_reg;
   assign bus.ram_write_value   = wr_data_reg;

   a_b_needs_a : assert property (@(posedge clk) disable iff (rst)
                                  grant_b_valid |-> grant_a_valid);
   a_distinct  : assert property (@(posedge clk) disable iff (rst)
                                  grant_b_valid |-> (grant_a_idx != grant_b_idx));
endmodule

// File: tb/tb_ram_read_scheduler.sv
// Scoreboard bench: a reference arbiter and RAM image predict grants, RAM port
// activity and tagged responses, which are compared every cycle.
module tb_ram_read_scheduler;
   localparam int NUM_REQ   = 3;
   localparam int ADDR_W    = 16;
   localparam int DATA_W    = 16;
   localparam int TAG_W     = 8;
   localparam int RAM_DEPTH = 700;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_read_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

   ram_read_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                        .TAG_W(TAG_W), .RAM_DEPTH(RAM_DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [DATA_W-1:0] init_val(input int a);
      return 16'h0d40 + DATA_W'(4 * a);
   endfunction

   // Block RAM stand-in: combinational read, write committed at the edge.
   logic [DATA_W-1:0] mem     [65536];
   logic              mem_wr  [65536];
   always @(posedge clk) begin
      if (bus.ram_write_enabled) begin
         mem[bus.ram_write_address]    <= bus.ram_write_value;
         mem_wr[bus.ram_write_address] <= 1'b1;
      end
   end
   assign bus.ram_read_value  = (mem_wr[bus.ram_read_address]  === 1'b1) ? mem[bus.ram_read_address]
                                                                          : init_val(int'(bus.ram_read_address));
   assign bus.ram_read_value2 = (mem_wr[bus.ram_read_address2] === 1'b1) ? mem[bus.ram_read_address2]
                                                                          : init_val(int'(bus.ram_read_address2));

   typedef struct {
      int                due;
      int                req;
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
      logic              err;
   } exp_t;

   exp_t              scb [$];
   logic [DATA_W-1:0] ref_mem [65536];
   int                rr_m;
   int                ga;
   int                gb;
   logic              wen_m;
   logic [ADDR_W-1:0] waddr_m;
   logic [DATA_W-1:0] wdata_m;
   logic [ADDR_W-1:0] rd_a_m;
   logic [ADDR_W-1:0] rd_b_m;
   int                cyc;
   int                n_vec;
   int                n_err;

   logic [NUM_REQ-1:0] last_ready;
   logic [DATA_W-1:0]  last_data [NUM_REQ];
   logic [TAG_W-1:0]   last_tag  [NUM_REQ];
   logic               last_err  [NUM_REQ];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [ADDR_W-1:0] req_addr_of(input int i);
      return bus.req_addr[i*ADDR_W +: ADDR_W];
   endfunction

   task automatic model_reset();
      scb.delete();
      rr_m  = 0;
      ga    = -1;
      gb    = -1;
      wen_m = 1'b0;
      rd_a_m = '0;
      rd_b_m = '0;
   endtask

   task automatic sample_checks();
      logic [NUM_REQ-1:0] elig;
      logic [NUM_REQ-1:0] exp_ready;
      logic [NUM_REQ-1:0] exp_rv;
      exp_t               e;
      ga = -1;
      gb = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
         elig[i] = bus.req_valid[i] && !rst && !(bus.wr_valid && (req_addr_of(i) == bus.wr_addr));
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         int p;
         p = (rr_m + k) % NUM_REQ;
         if (elig[p]) begin
            if (ga < 0) ga = p;
            else if (gb < 0) gb = p;
         end
      end
      exp_ready = '0;
      if (ga >= 0) exp_ready[ga] = 1'b1;
      if (gb >= 0) exp_ready[gb] = 1'b1;
      last_ready = bus.req_ready;
      check_eq("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      check_eq("wr_ready", 64'(bus.wr_ready), 64'(!rst));
      check_eq("ram_write_enabled", 64'(bus.ram_write_enabled), 64'(wen_m));
      if (wen_m) begin
         check_eq("ram_write_address", 64'(bus.ram_write_address), 64'(waddr_m));
         check_eq("ram_write_value", 64'(bus.ram_write_value), 64'(wdata_m));
      end
      check_eq("ram_read_address", 64'(bus.ram_read_address), 64'(rd_a_m));
      check_eq("ram_read_address2", 64'(bus.ram_read_address2), 64'(rd_b_m));
      exp_rv = '0;
      while (scb.size() > 0 && scb[0].due <= cyc) begin
         e = scb.pop_front();
         exp_rv[e.req] = 1'b1;
         check_eq($sformatf("resp_data[%0d]", e.req), 64'(bus.resp_data[e.req*DATA_W +: DATA_W]), 64'(e.data));
         check_eq($sformatf("resp_tag[%0d]", e.req), 64'(bus.resp_tag[e.req*TAG_W +: TAG_W]), 64'(e.tag));
         check_eq($sformatf("resp_err[%0d]", e.req), 64'(bus.resp_err[e.req]), 64'(e.err));
      end
      check_eq("resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
      for (int i = 0; i < NUM_REQ; i++) begin
         if (bus.resp_valid[i]) begin
            last_data[i] = bus.resp_data[i*DATA_W +: DATA_W];
            last_tag[i]  = bus.resp_tag[i*TAG_W +: TAG_W];
            last_err[i]  = bus.resp_err[i];
         end
      end
   endtask

   task automatic push_grant(input int i);
      exp_t        e;
      logic [ADDR_W-1:0] a;
      a     = req_addr_of(i);
      e.due = cyc + 1;
      e.req = i;
      e.tag = bus.req_tag[i*TAG_W +: TAG_W];
      e.err = (int'(a) >= RAM_DEPTH);
      e.data = e.err ? '0 : ref_mem[a];
      scb.push_back(e);
   endtask

   task automatic model_update();
      cyc++;
      if (rst) return;
      if (ga >= 0) begin
         rd_a_m = req_addr_of(ga);
         push_grant(ga);
      end
      if (gb >= 0) begin
         rd_b_m = req_addr_of(gb);
         push_grant(gb);
      end
      if (gb >= 0) rr_m = (gb + 1) % NUM_REQ;
      else if (ga >= 0) rr_m = (ga + 1) % NUM_REQ;
      wen_m = bus.wr_valid && (int'(bus.wr_addr) < RAM_DEPTH);
      if (wen_m) begin
         waddr_m = bus.wr_addr;
         wdata_m = bus.wr_data;
         ref_mem[bus.wr_addr] = bus.wr_data;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sample_checks();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input int addr, input int tag);
      bus.req_valid[i]                 = v;
      bus.req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
      bus.req_tag[i*TAG_W +: TAG_W]    = TAG_W'(tag);
   endtask

   task automatic set_wr(input logic v, input int addr, input int data);
      bus.wr_valid = v;
      bus.wr_addr  = ADDR_W'(addr);
      bus.wr_data  = DATA_W'(data);
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 0, 0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      cyc   = 0;
      for (int a = 0; a < 65536; a++) ref_mem[a] = init_val(a);
      for (int i = 0; i < NUM_REQ; i++) begin
         last_data[i] = '0;
         last_tag[i]  = '0;
         last_err[i]  = 1'b0;
      end
      clear_reqs();
      set_wr(1'b0, 0, 0);
      model_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;

      // single read, init image value and tag
      set_req(0, 1'b1, 52, 5);
      tick();
      check_eq("single_ready", 64'(last_ready), 64'(3'b001));
      clear_reqs();
      repeat (2) tick();
      check_eq("single_data", 64'(last_data[0]), 64'(16'h0e10));
      check_eq("single_tag", 64'(last_tag[0]), 64'(5));
      tick();

      // move pointer to 0, then all three contend
      set_req(2, 1'b1, 10, 20);
      tick();
      clear_reqs();
      set_req(0, 1'b1, 50, 10);
      set_req(1, 1'b1, 51, 11);
      set_req(2, 1'b1, 52, 12);
      tick();
      check_eq("rr_cycle1", 64'(last_ready), 64'(3'b011));
      tick();
      check_eq("rr_cycle2", 64'(last_ready), 64'(3'b101));
      repeat (2) tick();
      clear_reqs();
      repeat (3) tick();

      // same-cycle read-after-write is stalled and returns new data
      set_wr(1'b1, 53, 16'h1234);
      set_req(1, 1'b1, 53, 30);
      tick();
      check_eq("hazard_stall", 64'(last_ready), 64'(3'b000));
      set_wr(1'b0, 0, 0);
      tick();
      check_eq("hazard_grant", 64'(last_ready), 64'(3'b010));
      clear_reqs();
      repeat (3) tick();
      check_eq("hazard_data", 64'(last_data[1]), 64'(16'h1234));

      // out-of-range read and write
      set_req(0, 1'b1, 700, 9);
      tick();
      clear_reqs();
      repeat (3) tick();
      check_eq("oob_err", 64'(last_err[0]), 64'(1));
      check_eq("oob_data", 64'(last_data[0]), 64'(0));
      check_eq("oob_tag", 64'(last_tag[0]), 64'(9));
      set_wr(1'b1, 700, 16'hbeef);
      tick();
      set_wr(1'b0, 0, 0);
      repeat (2) tick();

      // reset with reads in flight drops them
      set_req(0, 1'b1, 100, 40);
      set_req(1, 1'b1, 101, 41);
      tick();
      clear_reqs();
      #2;
      rst = 1'b1;
      model_reset();
      repeat (3) tick();
      rst = 1'b0;
      repeat (3) tick();

      // pointer back at 0: requesters 1 and 2 take ports A and B
      set_req(1, 1'b1, 200, 50);
      set_req(2, 1'b1, 201, 51);
      tick();
      check_eq("post_rst_ready", 64'(last_ready), 64'(3'b110));
      check_eq("post_rst_addr_a", 64'(bus.ram_read_address), 64'(200));
      check_eq("post_rst_addr_b", 64'(bus.ram_read_address2), 64'(201));
      clear_reqs();
      repeat (5) tick();
      check_eq("idle_addr_a", 64'(bus.ram_read_address), 64'(200));
      check_eq("idle_addr_b", 64'(bus.ram_read_address2), 64'(201));

      // random mix of contention, hazards, writes and out-of-range accesses
      for (int c = 0; c < 60; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0) ? 700 + $urandom_range(0, 3) : $urandom_range(60, 67),
                    $urandom_range(0, 255));
         end
         set_wr(1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 705 : $urandom_range(60, 67),
                $urandom_range(0, 65535));
         tick();
      end
      clear_reqs();
      set_wr(1'b0, 0, 0);
      repeat (4) tick();
      check_eq("scoreboard_drained", 64'(scb.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ram_read_scheduler.md
Name: ram_read_scheduler

Overview:
- Shares the dual-read-port, single-write-port block RAM (single_blockram) between NUM_REQ tagged read requesters (fetch, decoder, MMU) and one writer (save-to-RAM stage).
- Each cycle, round-robin arbitration grants up to two reads, one per RAM read port, and registers the RAM address.
- Returns read data with the requester's instruction tag a fixed two edges after acceptance.
- Stalls same-cycle read-after-write hazards and flags out-of-range addresses.

Parameters:
NUM_REQ, 3, number of read requesters (2..8)
ADDR_W, 16, RAM address width
DATA_W, 16, RAM data width
TAG_W, 8, instruction tag width (instr_num)
RAM_DEPTH, 700, valid addresses are 0..RAM_DEPTH-1

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  read request per requester
req_ready  out  NUM_REQ  combinational grant; transfer when valid&&ready at posedge
req_addr  in  NUM_REQ*ADDR_W  flat, requester i at [i*ADDR_W +: ADDR_W]
req_tag  in  NUM_REQ*TAG_W  flat tags
resp_valid  out  NUM_REQ  one-cycle response pulse per requester, no backpressure
resp_data  out  NUM_REQ*DATA_W  flat read data
resp_tag  out  NUM_REQ*TAG_W  flat returned tags
resp_err  out  NUM_REQ  address was >= RAM_DEPTH; data forced 0
wr_valid  in  1  write request
wr_ready  out  1  always 1 when not in reset
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
ram_write_enabled  out  1  to RAM
ram_write_address  out  ADDR_W  to RAM
ram_write_value  out  DATA_W  to RAM
ram_read_address  out  ADDR_W  RAM port A address (registered)
ram_read_value  in  DATA_W  RAM port A data (combinational read)
ram_read_address2  out  ADDR_W  RAM port B address (registered)
ram_read_value2  in  DATA_W  RAM port B data

Behaviour:
- Reset (async, rst=1):
  - All outputs 0: resp_*, ram_*, req_ready, wr_ready.
  - Round-robin pointer rr_ptr=0.
  - Both in-flight slots invalid.
  - In-flight reads are dropped, with no response after reset is released.
- Arbitration (combinational, each cycle):
  - A requester is eligible when req_valid[i]=1, its address is not a hazard, and rst=0.
  - Scan i = rr_ptr, rr_ptr+1, ... mod NUM_REQ. The first eligible requester takes port A, the second takes port B.
  - req_ready is set only for these (at most 2).
- Hazard: a read is ineligible when wr_valid=1 and req_addr==wr_addr in the same cycle. It is granted at the earliest the next cycle and returns the new data.
- rr_ptr update at posedge:
  - With grants, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - With no grants, rr_ptr is unchanged.
- Read pipeline, request accepted at edge N:
  - Edge N: ram_read_address(2) <= addr. Slot records valid, requester index, tag, and err = (addr >= RAM_DEPTH).
  - Cycle N+1: RAM data is valid combinationally.
  - Edge N+1: resp_data/resp_tag/resp_err for that requester are registered, and resp_valid[i] is 1 for exactly one cycle (N+2).
  - Latency is 2 edges. Throughput is 2 reads/cycle sustained, fully pipelined.
- Idle port: the address register holds its last value, the slot is invalid, and no response is produced.
- Port B is never granted unless port A is granted that cycle.
- One requester receives at most one grant per cycle, so resp_valid[i] is never double-driven.
- Write path:
  - wr accepted at edge N drives ram_write_enabled=1 with addr/value during cycle N+1. The RAM commits at edge N+1.
  - ram_write_enabled returns to 0 the next cycle if no write follows.
  - Back-to-back writes are allowed, one per cycle.
- Read accepted at edge N+1 to the written address observes the new value (RAM committed at the same edge).
- Out-of-range write (addr >= RAM_DEPTH): dropped, ram_write_enabled stays 0.
- Out-of-range read: granted normally, resp_data=0, resp_err=1.
- req_addr/req_tag may change freely while req_ready=0. They are sampled only at the accepting edge.

Test Plan:
- Reset, then a single req on requester 0, addr 52, tag 5 → req_ready[0]=1 the same cycle. After 2 edges, resp_valid[0]=1 for one cycle with resp_data=16'h0e10 (init image) and resp_tag=5.
- All three requesters valid continuously (addrs 50/51/52, rr_ptr=0):
  - cycle 1 grants 0→A, 1→B, rr_ptr=2;
  - cycle 2 grants 2→A, 0→B, rr_ptr=1;
  - each response data matches ram[addr] at 2-edge latency.
- Write addr 53 data 16'h1234 with a same-cycle read addr 53 on requester 1 → req_ready[1]=0. The read is granted the next cycle, and the response returns 16'h1234.
- Read addr 700 tag 9 → resp_err=1, resp_data=0, resp_tag=9. Write addr 700 → ram_write_enabled never asserted.
- Two reads accepted, then rst asserted asynchronously one cycle later → resp_valid stays 0 during and after reset. rr_ptr=0 after release.
- Requesters 1 and 2 only, rr_ptr=0 → requester 1 on port A, requester 2 on port B. No requests for 3 cycles → no resp_valid pulses, ram addresses held.
